// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared FSM type and sizing constants for the sequence scanner.
package seq_scan_pkg;

    localparam int PAT_MAX_DEF = 8;
    localparam int LEN_W       = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_e;

    function automatic logic len_ok(input logic [LEN_W-1:0] len, input int pat_max);
        return (len != '0) && (32'(len) <= pat_max);
    endfunction

endpackage

// File: rtl/seq_match_unit.sv
// seq_match_unit: bit history shift register with length-masked pattern compare.
module seq_match_unit
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = PAT_MAX_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             shift_i,
    input  logic             bit_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             overlap_i,
    output logic             match_o
);

    logic [PAT_W-1:0] hist_q, hist_d, hist_sh, mask;
    logic [LEN_W-1:0] seen_q, seen_d, seen_sh;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (32'(len_i) > i);
        end
        hist_sh = (hist_q << 1) | PAT_W'(bit_i);
        seen_sh = (seen_q == '1) ? seen_q : seen_q + LEN_W'(1);
        // seen_sh guards against the cleared history faking a match
        match_o = shift_i
                && ((hist_sh & mask) == (pattern_i & mask))
                && (seen_sh >= len_i);
        hist_d = hist_q;
        seen_d = seen_q;
        if (clear_i) begin
            hist_d = '0;
            seen_d = '0;
        end else if (shift_i) begin
            if (match_o && !overlap_i) begin
                hist_d = '0;
                seen_d = '0;
            end else begin
                hist_d = hist_sh;
                seen_d = seen_sh;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
            seen_q <= '0;
        end else begin
            hist_q <= hist_d;
            seen_q <= seen_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: serial MSB-first pattern scanner with match counting.
// Define SEQ_SCAN_FIRSTPOS_EN to add the first_pos / first_pos_vld outputs.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int PAT_MAX = PAT_MAX_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WORD_W-1:0]           word_data,
    input  logic                        word_valid,
    output logic                        word_ready,
    input  logic [PAT_MAX-1:0]          cfg_pattern,
    input  logic [LEN_W-1:0]            cfg_len,
    input  logic                        cfg_overlap,
    output logic                        match_pulse,
    output logic [$clog2(WORD_W+1)-1:0] match_count,
    output logic                        busy,
    output logic                        done,
`ifdef SEQ_SCAN_FIRSTPOS_EN
    output logic [$clog2(WORD_W)-1:0]   first_pos,
    output logic                        first_pos_vld,
`endif
    output logic                        cfg_err
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int IDX_W = $clog2(WORD_W);

    scan_state_e        state_q;
    logic [WORD_W-1:0]  word_q;
    logic [PAT_MAX-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ready_q, busy_q, done_q, pulse_q, err_q;
    logic               accept, scanning, last_bit, hit;

    assign accept   = word_valid & ready_q;
    assign scanning = (state_q == S_SCAN);
    assign last_bit = (idx_q == IDX_W'(WORD_W - 1));

    seq_match_unit #(
        .PAT_W(PAT_MAX)
    ) u_match (
        .clk_i    (clk),
        .rst_ni   (reset),
        .clear_i  (accept),
        .shift_i  (scanning),
        .bit_i    (word_q[WORD_W-1]),
        .pattern_i(pat_q),
        .len_i    (len_q),
        .overlap_i(ovl_q),
        .match_o  (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        word_q  <= word_data;
                        pat_q   <= cfg_pattern;
                        len_q   <= cfg_len;
                        ovl_q   <= cfg_overlap;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        if (len_ok(cfg_len, PAT_MAX)) begin
                            busy_q  <= 1'b1;
                            state_q <= S_SCAN;
                        end else begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_SCAN: begin
                    word_q  <= word_q << 1;
                    idx_q   <= idx_q + IDX_W'(1);
                    pulse_q <= hit;
                    if (hit) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (last_bit) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_SCAN_FIRSTPOS_EN
    logic [IDX_W-1:0] fp_q;
    logic             fp_vld_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fp_q     <= '0;
            fp_vld_q <= 1'b0;
        end else if (accept) begin
            fp_q     <= '0;
            fp_vld_q <= 1'b0;
        end else if (scanning && hit && !fp_vld_q) begin
            fp_q     <= idx_q;
            fp_vld_q <= 1'b1;
        end
    end

    assign first_pos     = fp_q;
    assign first_pos_vld = fp_vld_q;
`endif

    assign word_ready  = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign match_pulse = pulse_q;
    assign cfg_err     = err_q;
    assign match_count = cnt_q;

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have parameter WORD_W, default 16, meaning the scanned word width in bits (4..32).
REQ-002 SHALL have parameter PAT_MAX, default 8, meaning the maximum pattern length in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port word_data, input, WORD_W bits: word to scan, sampled on accept.
REQ-006 SHALL have port word_valid, input, 1 bit: word_data is valid.
REQ-007 SHALL have port word_ready, output, 1 bit: the block can accept a word.
REQ-008 SHALL have port cfg_pattern, input, PAT_MAX bits: pattern, right-aligned, sampled on accept.
REQ-009 SHALL have port cfg_len, input, 4 bits: pattern length, legal range 1..PAT_MAX, sampled on accept.
REQ-010 SHALL have port cfg_overlap, input, 1 bit: 1 selects overlapping matches, 0 non-overlapping; sampled on accept.
REQ-011 SHALL have port match_pulse, output, 1 bit: one-cycle pulse per detected match.
REQ-012 SHALL have port match_count, output, $clog2(WORD_W+1) bits: number of matches in the current or last word.
REQ-013 SHALL have port busy, output, 1 bit: high while scanning.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at end of word.
REQ-015 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an illegal cfg_len is accepted.

Function
REQ-016 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-017 SHALL drive word_ready=1 only in IDLE; accept occurs on a rising edge with word_valid & word_ready.
REQ-018 On accept, SHALL latch word, pattern, length and mode; clear history, bits_seen, match_count and bit_idx; go to SCAN.
REQ-019 If cfg_len is 0 or greater than PAT_MAX on accept, SHALL pulse cfg_err, skip SCAN and go directly to DONE with match_count=0.
REQ-020 In SCAN, SHALL consume one bit per cycle, MSB first (word_data[WORD_W-1] first), for exactly WORD_W cycles.
REQ-021 SHALL shift each bit into the history; a match SHALL occur when the low cfg_len history bits equal the low cfg_len pattern bits and bits_seen >= cfg_len (bits_seen counting the bit just consumed).
REQ-022 SHALL assert match_pulse registered, in the cycle after the matching bit is consumed, and increment match_count in that same cycle.
REQ-023 With cfg_overlap=0, SHALL clear history and bits_seen after a match; with cfg_overlap=1, SHALL retain them.
REQ-024 After the last bit, SHALL enter DONE for one cycle, pulse done, then return to IDLE; accept-to-done latency SHALL be WORD_W+1 cycles.
REQ-025 A match on the last bit SHALL be counted, and its match_pulse SHALL coincide with done.
REQ-026 SHALL hold match_count stable from done until the next accept.
REQ-027 SHALL ignore changes on word_data and cfg_* while busy.

Reset
REQ-028 While reset is low, SHALL force state IDLE and outputs word_ready=0, busy=0, done=0, match_pulse=0, cfg_err=0, match_count=0, and clear all internal registers.
REQ-029 After reset deasserts, SHALL raise word_ready on the first clock edge; reset asserted mid-scan SHALL abandon the word without a done pulse.

Configuration
REQ-030 With SEQ_SCAN_FIRSTPOS_EN defined, SHALL add output first_pos ($clog2(WORD_W) bits plus a valid bit first_pos_vld), giving the bit_idx of the first match end in the word, cleared on accept and reset.
REQ-031 Without SEQ_SCAN_FIRSTPOS_EN, SHALL provide neither the port nor the logic.

Structure
REQ-032 Package seq_scan_pkg SHALL hold the FSM state enum, PAT_MAX default and the cfg_len width constant.
REQ-033 History register, length mask and compare SHALL reside in sub-module seq_match_unit; the FSM, counters and handshake SHALL reside in seq_scan_ctrl.

Verification
REQ-034 Test: pattern 4'b1001, len 4, overlap 0, word 16'h9249 -> matches at bit_idx 3, 9, 15; match_count=3; done 17 cycles after accept.
REQ-035 Test: same inputs with overlap 1 -> matches at bit_idx 3, 6, 9, 12, 15; match_count=5.
REQ-036 Test: len 1, pattern 1'b1, word 16'hFFFF, overlap 0 -> 16 pulses; match_count=16; last pulse coincides with done.
REQ-037 Test: cfg_len=0 with a valid word -> cfg_err and done pulse one cycle after accept; match_count=0; no match_pulse.
REQ-038 Test: reset driven low at bit 8 of a scan -> outputs zero immediately, no done pulse; word_ready=1 one edge after release.
REQ-039 Test: word_valid held high back-to-back -> second word accepted the cycle after done; cfg changes during scan have no effect.
